// File: rtl/adc_sample_decimator.sv
// adc_sample_decimator: boxcar-averages 2^k ADC conversions taken on SAMPLE rising edges
// and queues the averages in a show-ahead FIFO behind a valid/ready port.
module adc_sample_decimator #(
   parameter int NBITS        = 10,
   parameter int DEC_MAX_LOG2 = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          en_i,
   input  logic [2:0]                    dec_log2_i,
   input  logic [NBITS-1:0]              adc_data_i,
   input  logic                          adc_sample_i,
   output logic [NBITS-1:0]              out_data_o,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          ovf_o,
   input  logic                          ovf_clr_i
);
   localparam int AW = NBITS + DEC_MAX_LOG2;
   localparam int CW = DEC_MAX_LOG2;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   typedef enum logic {IDLE, ACC} state_t;
   state_t            r_state, w_state_n;
   logic              r_sample_q, w_evt, w_last, w_push, w_pop, w_full, w_wr;
   logic [AW-1:0]     r_acc, w_sum;
   logic [CW-1:0]     r_cnt;
   logic [CW:0]       w_span;
   logic [2:0]        r_k, w_k;
   logic [NBITS-1:0]  w_res;
   logic [NBITS-1:0]  r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wr, r_rd;
   logic [LW-1:0]     r_level;
   logic              r_ovf;
   assign w_evt  = adc_sample_i & ~r_sample_q;
   // The exponent is re-latched only when a window starts (cnt==0).
   assign w_k    = (r_cnt == '0) ? ((dec_log2_i > 3'(DEC_MAX_LOG2)) ? 3'(DEC_MAX_LOG2) : dec_log2_i) : r_k;
   assign w_span = (CW+1)'(1) << w_k;
   assign w_last = r_cnt == CW'(w_span - (CW+1)'(1));
   assign w_sum  = r_acc + AW'(adc_data_i);
   assign w_res  = NBITS'(w_sum >> w_k);
   always_comb begin
      w_state_n = r_state;
      w_push    = 1'b0;
      if (r_state == IDLE)
         w_state_n = en_i ? ACC : IDLE;
      else if (!en_i)
         w_state_n = IDLE;
      else
         w_push = w_evt & w_last;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_sample_q <= 1'b0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_k        <= '0;
      end else begin
         r_state    <= w_state_n;
         r_sample_q <= adc_sample_i;
         if (r_state == IDLE || !en_i) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else if (w_evt) begin
            r_k   <= w_k;
            r_acc <= w_last ? '0 : w_sum;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
         end
      end
   end
   assign out_valid_o = r_level != '0;
   assign out_data_o  = r_mem[r_rd];
   assign level_o     = r_level;
   assign ovf_o       = r_ovf;
   assign w_pop       = out_valid_o & out_ready_i;
   assign w_full      = r_level == LW'(FIFO_DEPTH);
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign w_wr        = w_push & (~w_full | w_pop);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mem   <= '{default: '0};
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr] <= w_res;
            r_wr        <= r_wr + PW'(1);
         end
         if (w_pop)
            r_rd <= r_rd + PW'(1);
         r_level <= r_level + LW'(w_wr) - LW'(w_pop);
         r_ovf   <= (w_push & w_full & ~w_pop) | (r_ovf & ~ovf_clr_i);
      end
   end
endmodule

// File: tb/tb_adc_sample_decimator.sv
// tb_adc_sample_decimator: randomized scoreboard bench; a window-averaging model
// queues expected words, a negedge monitor compares them against the DUT.
module tb_adc_sample_decimator;
   logic       clk_i = 1'b0;
   logic       rst_ni, en_i, adc_sample_i, out_valid_o, out_ready_i, ovf_o, ovf_clr_i;
   logic [2:0] dec_log2_i, level_o;
   logic [9:0] adc_data_i, out_data_o;
   int checks = 0, failures = 0;
   int sb[$];
   int m_lvl, m_n, m_sum, m_k, res;
   bit m_on, m_ovf, m_sq, ev, pop, push;

   adc_sample_decimator dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .dec_log2_i(dec_log2_i),
      .adc_data_i(adc_data_i), .adc_sample_i(adc_sample_i), .out_data_o(out_data_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .level_o(level_o),
      .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i));

   always #5 clk_i = ~clk_i;

   function automatic void chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", n, act, exp, $time);
      end
   endfunction

   // Reference: collect 2^k samples per window, average by integer division.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_on = 0; m_n = 0; m_sum = 0; m_lvl = 0; m_ovf = 0; m_sq = 0; m_k = 0;
         sb.delete();
      end else begin
         ev = adc_sample_i && !m_sq;
         m_sq = adc_sample_i;
         push = 0;
         if (!m_on) begin
            m_n = 0; m_sum = 0; m_on = en_i;
         end else if (!en_i) begin
            m_on = 0; m_n = 0; m_sum = 0;
         end else if (ev) begin
            if (m_n == 0) m_k = (dec_log2_i > 4) ? 4 : int'(dec_log2_i);
            m_sum += int'(adc_data_i);
            m_n++;
            if (m_n == (1 << m_k)) begin
               push = 1; res = m_sum / (1 << m_k); m_n = 0; m_sum = 0;
            end
         end
         pop = (m_lvl > 0) && out_ready_i;
         if (pop) m_lvl--;
         if (ovf_clr_i) m_ovf = 0;
         if (push) begin
            if (m_lvl < 4) begin m_lvl++; sb.push_back(res); end
            else m_ovf = 1;
         end
      end
   end

   always @(negedge clk_i) begin
      chk("valid", int'(out_valid_o), int'(m_lvl > 0));
      chk("level", int'(level_o), m_lvl);
      chk("ovf", int'(ovf_o), int'(m_ovf));
      if (out_valid_o) begin
         if (sb.size() == 0) chk("unexpected_output", int'(out_data_o), -1);
         else begin
            chk("data", int'(out_data_o), sb[0]);
            if (out_ready_i) void'(sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk_i); #1;
   endtask

   task automatic send(input int d);
      adc_data_i = 10'(d); adc_sample_i = 1'b1;
      step();
      adc_sample_i = 1'b0; adc_data_i = 10'($urandom);
      step();
      repeat ($urandom_range(0, 2)) step();
   endtask

   initial begin
      rst_ni = 0; en_i = 0; dec_log2_i = 0; adc_data_i = 0; adc_sample_i = 0;
      out_ready_i = 0; ovf_clr_i = 0;
      repeat (3) step();
      chk("reset_data", int'(out_data_o), 0);
      rst_ni = 1;
      en_i = 1; out_ready_i = 1; step();
      send(5); send(1023); send(0);
      dec_log2_i = 2; send(100); send(101); send(102); send(103);
      repeat (4) send(1023);
      dec_log2_i = 4; repeat (16) send(1023);
      dec_log2_i = 0; out_ready_i = 0;
      repeat (6) send($urandom_range(0, 1023));
      chk("t4_level", int'(level_o), 4);
      chk("t4_ovf", int'(ovf_o), 1);
      out_ready_i = 1; repeat (6) step();
      ovf_clr_i = 1; step(); ovf_clr_i = 0; step();
      chk("t4_ovf_clr", int'(ovf_o), 0);
      dec_log2_i = 3; repeat (5) send($urandom_range(0, 1023));
      en_i = 0; step(); en_i = 1; step();
      repeat (8) send(200);
      repeat (3) step();
      out_ready_i = 0; dec_log2_i = 0; send(33); send(44);
      dec_log2_i = 1; send(7);
      #2 rst_ni = 0;
      #1 chk("t6_valid", int'(out_valid_o), 0);
      chk("t6_level", int'(level_o), 0);
      step(); step(); rst_ni = 1; out_ready_i = 1; step();
      send(10); send(20); repeat (3) step();
      for (int i = 0; i < 400; i++) begin
         out_ready_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) dec_log2_i = 3'($urandom);
         if ($urandom_range(0, 29) == 0) begin en_i = 0; step(); en_i = 1; end
         ovf_clr_i = ($urandom_range(0, 19) == 0);
         send($urandom_range(0, 1023));
         ovf_clr_i = 0;
      end
      en_i = 0; out_ready_i = 1;
      for (int i = 0; i < 50 && m_lvl > 0; i++) step();
      step();
      chk("drain_level", m_lvl, 0);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
